// File: rtl/layer_stream_sequencer.sv
// Streams one feature-map frame from the on-chip buffer into a conv layer and tracks completion.
// Optional macro LAYER_SEQ_PERF_EN adds the perf_cycles start-to-done cycle counter output.
//
// state  | meaning
// IDLE   | waiting for start; err_timeout holds its last value
// STREAM | issuing buffer reads (one per unstalled cycle) and counting Valid_Out beats
// DRAIN  | all reads issued; waiting for the remaining Valid_Out beats or the timeout
// DONE   | one-cycle done pulse, then back to IDLE
module layer_stream_sequencer #(
  parameter int DATA_WIDHT    = 32,
  parameter int CHANNEL_IN    = 64,
  parameter int IMG_WIDHT     = 44,
  parameter int IMG_HEIGHT    = 44,
  parameter int OUT_PIXELS    = 1936,
  parameter int ADDR_W        = 11,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               stall,
  output logic                               buf_rd_en,
  output logic [ADDR_W-1:0]                  buf_rd_addr,
  input  logic [DATA_WIDHT*CHANNEL_IN-1:0]   buf_rd_data,
  output logic [DATA_WIDHT*CHANNEL_IN-1:0]   layer_data_in,
  output logic                               layer_valid_in,
  input  logic                               layer_valid_out,
  output logic                               busy,
  output logic                               done,
  output logic                               err_timeout,
  output logic [$clog2(IMG_HEIGHT)-1:0]      row,
  output logic [$clog2(IMG_WIDHT)-1:0]       col
`ifdef LAYER_SEQ_PERF_EN
  ,
  output logic [31:0]                        perf_cycles
`endif
);

  localparam int NPIX  = IMG_WIDHT * IMG_HEIGHT;
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDHT);
  localparam int OUT_W = $clog2(OUT_PIXELS + 1);
  localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
  localparam logic [OUT_W-1:0]  OUT_FULL  = OUT_W'(OUT_PIXELS);
  localparam logic [OUT_W-1:0]  OUT_LAST  = OUT_W'(OUT_PIXELS - 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_WIDHT - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   rd_ptr;
  logic [OUT_W-1:0]    out_cnt;
  logic [TMR_W-1:0]    idle_tmr;
  logic                valid_q;
  logic                start_acc;
  logic                last_rd;
  logic                tmo_hit;
  logic                beat;
  logic                frame_full;

  assign buf_rd_addr    = rd_ptr;
  assign layer_data_in  = buf_rd_data;
  assign layer_valid_in = valid_q;

  // A beat landing on this very cycle already counts toward completion.
  assign beat       = layer_valid_out && ((state == S_STREAM) || (state == S_DRAIN));
  assign frame_full = (out_cnt == OUT_FULL) || (beat && (out_cnt == OUT_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    buf_rd_en = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    start_acc = 1'b0;
    last_rd   = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        busy      = 1'b1;
        buf_rd_en = !stall;
        if (!stall && (rd_ptr == LAST_ADDR)) begin
          last_rd   = 1'b1;
          state_nxt = frame_full ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (frame_full) begin
          state_nxt = S_DONE;
        end else if (!layer_valid_out && (idle_tmr <= TMR_ONE)) begin
          tmo_hit   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // idle_tmr is a down-counter reloaded on every Valid_Out beat; it keeps running
  // through STREAM so a layer that stalls early is caught as soon as DRAIN begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      out_cnt     <= '0;
      idle_tmr    <= '0;
      err_timeout <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      valid_q <= buf_rd_en;
      if (start_acc) begin
        rd_ptr      <= '0;
        out_cnt     <= '0;
        idle_tmr    <= TMR_LOAD;
        err_timeout <= 1'b0;
      end else begin
        if (buf_rd_en) begin
          rd_ptr <= last_rd ? '0 : rd_ptr + 1'b1;
        end
        if (beat && (out_cnt != OUT_FULL)) begin
          out_cnt <= out_cnt + 1'b1;
        end
        if (busy) begin
          if (layer_valid_out) begin
            idle_tmr <= TMR_LOAD;
          end else if (idle_tmr != '0) begin
            idle_tmr <= idle_tmr - 1'b1;
          end
        end
        if (tmo_hit) begin
          err_timeout <= 1'b1;
        end
      end
    end
  end

  // row/col name the pixel currently on layer_valid_in and wrap to 0 after the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (valid_q) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

`ifdef LAYER_SEQ_PERF_EN
  // Counts the accepting cycle plus every non-IDLE cycle up to and including DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (start_acc) begin
      perf_cycles <= 32'd1;
    end else if ((state != S_IDLE) && (perf_cycles != 32'hFFFF_FFFF)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule
